// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader: beats fill a shadow bank, and a sample
// strobe copies the whole bank into the active coefficients in one edge.
//
// state | meaning
// IDLE  | waiting for the first beat of a load (index is 0)
// LOAD  | collecting beats into the shadow bank
// ARMED | full bank held in shadow, waiting for sample_strobe to commit
module fir_coeff_loader #(
    parameter int WIDTH = 16,
    parameter int DELAY = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [WIDTH-1:0]                cfg_data,
    input  logic                            cfg_last,
    input  logic                            cfg_abort,
    input  logic                            sample_strobe,
    output logic [0:DELAY-1][WIDTH-1:0]     coeff,
    output logic                            busy,
    output logic                            commit,
    output logic                            err_len
);

    localparam int IDXW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DELAY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t                         state, state_nxt;
    logic [IDXW-1:0]                idx, idx_nxt;
    logic [0:DELAY-1][WIDTH-1:0]    shadow;
    logic                           ready_en;
    logic                           accept;
    logic                           wr_en;
    logic                           copy_en;
    logic                           commit_nxt;
    logic                           err_nxt;

    // ready_en keeps cfg_ready low through reset and rises on the first edge after it
    assign cfg_ready = ready_en && (state != ARMED);
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        wr_en      = 1'b0;
        copy_en    = 1'b0;
        commit_nxt = 1'b0;
        err_nxt    = 1'b0;
        if (cfg_abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        wr_en = 1'b1;
                        if (cfg_last && (idx == LAST_IDX)) begin
                            state_nxt = ARMED;
                            idx_nxt   = '0;
                        end else if (cfg_last || (idx == LAST_IDX)) begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                            err_nxt   = 1'b1;
                        end else begin
                            state_nxt = LOAD;
                            idx_nxt   = idx + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (sample_strobe) begin
                        copy_en    = 1'b1;
                        commit_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            ready_en <= 1'b0;
            commit   <= 1'b0;
            err_len  <= 1'b0;
            shadow   <= '0;
            coeff    <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            ready_en <= 1'b1;
            commit   <= commit_nxt;
            err_len  <= err_nxt;
            if (wr_en) begin
                shadow[idx] <= cfg_data;
            end
            if (copy_en) begin
                coeff <= shadow;
            end
        end
    end

endmodule
